// File: rtl/recorder_ctrl.sv
// Sample-memory recorder controller: debounced record/play buttons drive an
// IDLE/RECORD/PLAY sequencer that emits one-cycle write/read strobes per sample tick.
module recorder_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_rec,
    input  logic              btn_play,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic              recording,
    output logic              playing,
    output logic [ADDR_W:0]   rec_len
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

    state_t            state, state_n;
    logic [1:0]        raw, lvl, flip, press;
    logic [CW-1:0]     cnt [2];
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W:0]   len_n;
    logic              wr_n, rd_n, strobe;

    assign raw    = {btn_play, btn_rec};
    assign strobe = wr_en | rd_en;

    // A press fires on the same edge the debounced level rises.
    always_comb begin
        flip  = '0;
        press = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            flip[i]  = (raw[i] != lvl[i]) && (cnt[i] == CNT_LAST);
            press[i] = flip[i] & raw[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lvl <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (raw[i] != lvl[i]) begin
                    if (flip[i]) begin
                        lvl[i] <= raw[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        len_n   = rec_len;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (press[0]) begin
                    state_n = RECORD;
                    addr_n  = '0;
                    len_n   = '0;
                end else if (press[1] && rec_len != '0) begin
                    state_n = PLAY;
                    addr_n  = '0;
                end
            end
            RECORD: begin
                // Strobe completion first; a press in the same cycle then overrides state.
                if (wr_en) begin
                    addr_n = addr + 1'b1;
                    len_n  = {1'b0, addr} + 1'b1;
                    if (addr == '1) state_n = IDLE;
                end
                if (press[0])                   state_n = IDLE;
                else if (sample_tick && !strobe) wr_n   = 1'b1;
            end
            PLAY: begin
                if (rd_en) begin
                    addr_n = addr + 1'b1;
                    if ({1'b0, addr} == rec_len - 1'b1) begin
                        state_n = IDLE;
                        addr_n  = '0;
                    end
                end
                if (press[0]) begin
                    state_n = RECORD;
                    addr_n  = '0;
                    len_n   = '0;
                end else if (press[1]) begin
                    state_n = IDLE;
                end else if (sample_tick && !strobe) begin
                    rd_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            rec_len   <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            recording <= 1'b0;
            playing   <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            rec_len   <= len_n;
            wr_en     <= wr_n;
            rd_en     <= rd_n;
            recording <= (state_n == RECORD);
            playing   <= (state_n == PLAY);
        end
    end

endmodule

// File: tb/tb_recorder_ctrl.sv
// Directed bench for recorder_ctrl: a behavioural model checked every cycle,
// plus literal expectations on strobe address sequences and end states.
module tb_recorder_ctrl;

    localparam int ADDR_W = 4;
    localparam int DC     = 4;
    localparam int CAP    = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset, btn_rec, btn_play, sample_tick;
    logic [ADDR_W-1:0] addr;
    logic              wr_en, rd_en, recording, playing;
    logic [ADDR_W:0]   rec_len;

    int total = 0;
    int bad   = 0;

    recorder_ctrl #(.ADDR_W(ADDR_W), .DEBOUNCE_CYC(DC)) dut (
        .clock(clock), .reset(reset), .btn_rec(btn_rec), .btn_play(btn_play),
        .sample_tick(sample_tick), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .recording(recording), .playing(playing), .rec_len(rec_len)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=record 2=play; button history as run lengths.
    int m_lvl[2], m_run[2];
    int m_mode = 0, m_addr = 0, m_len = 0, m_wr = 0, m_rd = 0;
    bit started = 0;

    always @(posedge clock) begin
        int raw[2], ev[2], nmode, had_strobe, moved;
        raw[0] = int'(btn_rec);
        raw[1] = int'(btn_play);
        if (!reset) begin
            started = 1;
            m_lvl = '{0, 0}; m_run = '{0, 0};
            m_mode = 0; m_addr = 0; m_len = 0; m_wr = 0; m_rd = 0;
        end else if (started) begin
            for (int i = 0; i < 2; i++) begin
                ev[i] = 0;
                if (raw[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_lvl[i] = raw[i];
                        m_run[i] = 0;
                        ev[i] = raw[i];
                    end
                end else m_run[i] = 0;
            end
            nmode = m_mode;
            had_strobe = m_wr | m_rd;
            if (m_wr != 0) begin
                m_len  = m_addr + 1;
                m_addr = (m_addr + 1) % CAP;
                if (m_len == CAP) nmode = 0;
            end
            if (m_rd != 0) begin
                m_addr = m_addr + 1;
                if (m_addr == m_len) begin
                    nmode = 0;
                    m_addr = 0;
                end
            end
            moved = 0;
            if (ev[0] != 0) begin
                moved = 1;
                if (m_mode == 1) nmode = 0;
                else begin
                    nmode = 1; m_addr = 0; m_len = 0;
                end
            end else if (ev[1] != 0) begin
                if (m_mode == 2) begin
                    nmode = 0; moved = 1;
                end else if (m_mode == 0 && m_len != 0) begin
                    nmode = 2; m_addr = 0; moved = 1;
                end
            end
            m_wr = 0; m_rd = 0;
            if (sample_tick && had_strobe == 0 && moved == 0) begin
                if (m_mode == 1) m_wr = 1;
                if (m_mode == 2) m_rd = 1;
            end
            m_mode = nmode;
        end
    end

    int wq[$], rq[$];

    always @(negedge clock) begin
        if (started) begin
            chk("addr", int'(addr), m_addr);
            chk("wr_en", int'(wr_en), m_wr);
            chk("rd_en", int'(rd_en), m_rd);
            chk("recording", int'(recording), int'(m_mode == 1));
            chk("playing", int'(playing), int'(m_mode == 2));
            chk("rec_len", int'(rec_len), m_len);
            chk("strobe_excl", int'(wr_en & rd_en), 0);
            if (wr_en) wq.push_back(int'(addr));
            if (rd_en) rq.push_back(int'(addr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input bit rec, input bit play);
        btn_rec = rec; btn_play = play;
        cyc(6);
        btn_rec = 0; btn_play = 0;
        cyc(8);
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            sample_tick = 1; cyc(1);
            sample_tick = 0; cyc(gap - 1);
        end
    endtask

    task automatic chk_seq(input string name, input int q[$], input int n);
        chk({name, "_count"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++) chk(name, q[i], i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; btn_rec = 0; btn_play = 0; sample_tick = 0;
        cyc(3);
        chk("rst_recording", int'(recording), 0);
        chk("rst_rec_len", int'(rec_len), 0);
        chk("rst_addr", int'(addr), 0);
        reset = 1;
        cyc(2);

        // Short glitch: 3 cycles is below the debounce threshold.
        btn_rec = 1; cyc(3); btn_rec = 0; cyc(8);
        chk("glitch_no_rec", int'(recording), 0);
        btn_rec = 1; cyc(4);
        chk("rec_after_4", int'(recording), 1);
        btn_rec = 0; cyc(8);

        wq.delete();
        ticks(5, 10);
        press(1, 0);
        chk("rec5_idle", int'(recording), 0);
        chk("rec5_len", int'(rec_len), 5);
        chk_seq("rec5_waddr", wq, 5);

        rq.delete();
        press(0, 1);
        chk("play_started", int'(playing), 1);
        ticks(8, 10);
        chk("play_done", int'(playing), 0);
        chk("play_addr0", int'(addr), 0);
        chk_seq("play_raddr", rq, 5);

        wq.delete();
        press(1, 0);
        ticks(20, 4);
        cyc(4);
        chk("full_len", int'(rec_len), CAP);
        chk("full_idle", int'(recording), 0);
        chk_seq("full_waddr", wq, CAP);

        reset = 0; cyc(1); reset = 1;
        chk("len_cleared", int'(rec_len), 0);
        press(0, 1);
        chk("play_empty_playing", int'(playing), 0);
        chk("play_empty_rec", int'(recording), 0);
        press(1, 1);
        chk("both_recording", int'(recording), 1);
        chk("both_playing", int'(playing), 0);
        ticks(3, 4);
        chk("pre_reset_addr", int'(addr), 3);
        chk("pre_reset_len", int'(rec_len), 3);
        reset = 0; cyc(1);
        chk("abort_addr", int'(addr), 0);
        chk("abort_len", int'(rec_len), 0);
        chk("abort_rec", int'(recording), 0);
        chk("abort_wr", int'(wr_en), 0);
        reset = 1;
        cyc(2);

        // Button held through reset release.
        btn_rec = 1; reset = 0; cyc(2); reset = 1;
        cyc(3);
        chk("held_3", int'(recording), 0);
        cyc(1);
        chk("held_4", int'(recording), 1);
        btn_rec = 0; cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
